// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the MCS8 bus controller: T-state codes, cycle types, FSM states.
// No logic; constants and a small decode helper only.
// Backpressure: not applicable.
package cpu_bus_pkg;

  // Core T-state codes as driven on STATE_O
  localparam logic [2:0] ST_T1   = 3'b010;
  localparam logic [2:0] ST_T2   = 3'b100;
  localparam logic [2:0] ST_T3   = 3'b001;
  localparam logic [2:0] ST_T4   = 3'b111;
  localparam logic [2:0] ST_T5   = 3'b101;
  localparam logic [2:0] ST_T1I  = 3'b110;
  localparam logic [2:0] ST_STOP = 3'b011;
  localparam logic [2:0] ST_WAIT = 3'b000;

  // Cycle types carried in the top two bits of the T2 byte
  localparam logic [1:0] CYC_PCI = 2'b00;
  localparam logic [1:0] CYC_PCC = 2'b01;
  localparam logic [1:0] CYC_PCR = 2'b10;
  localparam logic [1:0] CYC_PCW = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GOT_L,
    S_GOT_H,
    S_RD_WAIT,
    S_IO,
    S_WR_CAP,
    S_DONE
  } bus_state_e;

  // Both plain T1 and the interrupt-acknowledge T1I open a new machine cycle
  function automatic logic is_t1(input logic [2:0] st);
    return (st == ST_T1) || (st == ST_T1I);
  endfunction

endpackage

// File: rtl/cpu_busctl_wrbuf.sv
// One-entry posted-write buffer: holds write data and raises the memory write request.
// Latency: request visible the clock after load; cleared the clock after the memory ack.
// Backpressure: full_o tells the controller to stall the next access until the ack drains it.
module cpu_busctl_wrbuf (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_dat_i,
  input  logic       ack_i,
  output logic       full_o,
  output logic [7:0] dat_o
);

  logic       full_q, full_d;
  logic [7:0] dat_q, dat_d;

  // Fill on load, empty on an ack that arrives while a write is pending
  always_comb begin
    full_d = full_q;
    dat_d  = dat_q;
    if (load_i) begin
      full_d = 1'b1;
      dat_d  = load_dat_i;
    end else if (ack_i && full_q) begin
      full_d = 1'b0;
    end
  end

  // Buffer state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      dat_q  <= 8'h00;
    end else begin
      full_q <= full_d;
      dat_q  <= dat_d;
    end
  end

  assign full_o = full_q;
  assign dat_o  = dat_q;

endmodule

// File: rtl/cpu_busctl.sv
// MCS8 bus controller: rebuilds address/cycle from T-states and runs memory/IO transfers.
// Latency: read request the clock after T2; READY_O back one clock after MEM_ACK_I; writes posted.
// Backpressure: READY_O drops at T2 while a posted write is still pending (CPU_BUSCTL_INTACK_EN enables int-ack bypass).
module cpu_busctl
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              SYNC_I,
  input  logic [2:0]        STATE_I,
  input  logic [7:0]        CPU_DAT_I,
  output logic [7:0]        CPU_DAT_O,
  output logic              READY_O,
  output logic              HALT_O,
  input  logic [7:0]        INT_VEC_I,
  output logic [ADDR_W-1:0] ADDR_O,
  output logic [1:0]        CYCLE_O,
  output logic              MEM_RD_O,
  output logic              MEM_WR_O,
  output logic [7:0]        WDAT_O,
  input  logic [7:0]        MEM_DAT_I,
  input  logic              MEM_ACK_I,
  output logic              IO_STB_O,
  input  logic [7:0]        IO_DAT_I
);

  localparam int HI_W = ADDR_W - 8;

  bus_state_e        state_q, state_d;
  logic [7:0]        addr_l_q, addr_l_d;
  logic [HI_W-1:0]   addr_h_q, addr_h_d;
  logic [1:0]        cyc_sh_q, cyc_sh_d;
  logic              intack_q, intack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        cycle_q, cycle_d;
  logic [7:0]        cpu_dat_q, cpu_dat_d;
  logic              ready_q, ready_d;
  logic              mem_rd_q, mem_rd_d;
  logic              io_stb_q, io_stb_d;
  logic              rd_acked_q, rd_acked_d;
  logic              halt_q, halt_d;

  logic              samp;
  logic              dispatch;
  logic [ADDR_W-1:0] disp_addr;
  logic [1:0]        disp_cyc;
  logic              wb_load;
  logic              wb_full;
  logic [7:0]        wb_dat;
  logic              intack_skip;

  assign samp = SYNC_I;

`ifdef CPU_BUSCTL_INTACK_EN
  assign intack_skip = intack_q;
`else
  // T1I behaves as T1; the acknowledge flag and vector have no consumer
  assign intack_skip = 1'b0;
  logic unused_intack;
  assign unused_intack = ^{intack_q, INT_VEC_I};
`endif

  // Next-state, shadow capture and dispatch decisions
  always_comb begin
    state_d    = state_q;
    addr_l_d   = addr_l_q;
    addr_h_d   = addr_h_q;
    cyc_sh_d   = cyc_sh_q;
    intack_d   = intack_q;
    addr_d     = addr_q;
    cycle_d    = cycle_q;
    cpu_dat_d  = cpu_dat_q;
    ready_d    = ready_q;
    mem_rd_d   = mem_rd_q;
    rd_acked_d = rd_acked_q;
    io_stb_d   = 1'b0;
    halt_d     = (STATE_I == ST_STOP);
    wb_load    = 1'b0;
    dispatch   = 1'b0;
    disp_addr  = {addr_h_q, addr_l_q};
    disp_cyc   = cyc_sh_q;

    case (state_q)
      S_IDLE, S_GOT_L, S_IO, S_DONE: begin
        if (state_q == S_IO) state_d = S_DONE;
        if (state_q == S_DONE && samp && STATE_I == ST_STOP) state_d = S_IDLE;
        if (samp && is_t1(STATE_I)) begin
          addr_l_d = CPU_DAT_I;
          intack_d = (STATE_I == ST_T1I);
          state_d  = S_GOT_L;
        end else if (state_q == S_GOT_L && samp && STATE_I == ST_T2) begin
          addr_h_d = CPU_DAT_I[HI_W-1:0];
          cyc_sh_d = CPU_DAT_I[7:6];
          // An ack landing on this edge drains the buffer first, so no stall
          if (wb_full && !MEM_ACK_I) begin
            ready_d = 1'b0;
            state_d = S_GOT_H;
          end else begin
            dispatch  = 1'b1;
            disp_addr = {CPU_DAT_I[HI_W-1:0], addr_l_q};
            disp_cyc  = CPU_DAT_I[7:6];
          end
        end
      end
      S_GOT_H: begin
        // Dispatch from the shadows once the pending write has fully drained
        if (!wb_full) dispatch = 1'b1;
      end
      S_RD_WAIT: begin
        if (!rd_acked_q) begin
          if (MEM_ACK_I) begin
            cpu_dat_d  = MEM_DAT_I;
            rd_acked_d = 1'b1;
          end
        end else begin
          mem_rd_d   = 1'b0;
          ready_d    = 1'b1;
          rd_acked_d = 1'b0;
          state_d    = S_DONE;
        end
      end
      S_WR_CAP: begin
        if (samp && STATE_I == ST_T3) begin
          wb_load = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (dispatch) begin
      addr_d  = disp_addr;
      cycle_d = disp_cyc;
      case (disp_cyc)
        CYC_PCC: begin
          io_stb_d  = 1'b1;
          cpu_dat_d = IO_DAT_I;
          ready_d   = 1'b1;
          state_d   = S_IO;
        end
        CYC_PCW: begin
          ready_d = 1'b1;
          state_d = S_WR_CAP;
        end
        default: begin
          if (intack_skip && disp_cyc == CYC_PCI) begin
            cpu_dat_d = INT_VEC_I;
            ready_d   = 1'b1;
            state_d   = S_DONE;
          end else begin
            mem_rd_d   = 1'b1;
            ready_d    = 1'b0;
            rd_acked_d = 1'b0;
            state_d    = S_RD_WAIT;
          end
        end
      endcase
    end
  end

  // Controller state, shadows and registered outputs
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q    <= S_IDLE;
      addr_l_q   <= 8'h00;
      addr_h_q   <= '0;
      cyc_sh_q   <= 2'b00;
      intack_q   <= 1'b0;
      addr_q     <= '0;
      cycle_q    <= 2'b00;
      cpu_dat_q  <= 8'h00;
      ready_q    <= 1'b1;
      mem_rd_q   <= 1'b0;
      io_stb_q   <= 1'b0;
      rd_acked_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_l_q   <= addr_l_d;
      addr_h_q   <= addr_h_d;
      cyc_sh_q   <= cyc_sh_d;
      intack_q   <= intack_d;
      addr_q     <= addr_d;
      cycle_q    <= cycle_d;
      cpu_dat_q  <= cpu_dat_d;
      ready_q    <= ready_d;
      mem_rd_q   <= mem_rd_d;
      io_stb_q   <= io_stb_d;
      rd_acked_q <= rd_acked_d;
      halt_q     <= halt_d;
    end
  end

  cpu_busctl_wrbuf u_wrbuf (
    .clk_i      (CLK_I),
    .rst_i      (RST_I),
    .load_i     (wb_load),
    .load_dat_i (CPU_DAT_I),
    .ack_i      (MEM_ACK_I),
    .full_o     (wb_full),
    .dat_o      (wb_dat)
  );

  assign CPU_DAT_O = cpu_dat_q;
  assign READY_O   = ready_q;
  assign HALT_O    = halt_q;
  assign ADDR_O    = addr_q;
  assign CYCLE_O   = cycle_q;
  assign MEM_RD_O  = mem_rd_q;
  assign MEM_WR_O  = wb_full;
  assign WDAT_O    = wb_dat;
  assign IO_STB_O  = io_stb_q;

endmodule

// File: doc/cpu_busctl.md
# cpu_busctl

Bus controller between the MCS8 `cpu` core and the external memory and I/O fabric. It decodes the core's `STATE_O` (3-bit T-state code) and multiplexed `DAT_O` to rebuild the 14-bit address and the 2-bit cycle type. It then runs memory read, memory write and I/O transfers, and returns read data plus `READY` to the core. Writes are posted through a one-entry buffer, so the core stalls only when a second access arrives before the previous write has drained.

## Interface
Parameters:
- `ADDR_W`, default 14: address width; the high byte contributes `ADDR_W-8` bits.

Ports:
- `CLK_I`  in  1  single system clock, rising edge.
- `RST_I`  in  1  asynchronous active-high reset.
- `SYNC_I`  in  1  core `SYNC_O`; state inputs are sampled on rising `CLK_I` while `SYNC_I`=1 ("sample edge").
- `STATE_I`  in  3  core T-state code: T1=010, T2=100, T3=001, T4=111, T5=101, T1I=110, STOP=011, WAIT=000.
- `CPU_DAT_I`  in  8  core `DAT_O`.
- `CPU_DAT_O`  out  8  read data to the core.
- `READY_O`  out  1  to core `READY_I`.
- `HALT_O`  out  1  high while `STATE_I`=STOP.
- `INT_VEC_I`  in  8  instruction byte (RST opcode) returned during an interrupt-acknowledge fetch.
- `ADDR_O`  out  `ADDR_W`  memory/IO address.
- `CYCLE_O`  out  2  cycle type: 00 PCI, 01 PCC, 10 PCR, 11 PCW.
- `MEM_RD_O`  out  1  memory read request, level.
- `MEM_WR_O`  out  1  memory write request, level.
- `WDAT_O`  out  8  write data.
- `MEM_DAT_I`  in  8  memory read data, valid with ack.
- `MEM_ACK_I`  in  1  memory completion, one clock per request.
- `IO_STB_O`  out  1  one-clock I/O strobe.
- `IO_DAT_I`  in  8  I/O input data.

## Operation
- Reset values: `ADDR_O`=0, `CYCLE_O`=00, `CPU_DAT_O`=0, `WDAT_O`=0, `READY_O`=1, `MEM_RD_O`=0, `MEM_WR_O`=0, `IO_STB_O`=0, `HALT_O`=0. The write buffer is emptied and the FSM goes to IDLE.
- FSM states: IDLE → GOT_L → GOT_H → RD_WAIT / IO / WR_CAP → DONE → IDLE.
- **T1 or T1I** sample edge: `CPU_DAT_I` goes into the low-address shadow register. The FSM moves to GOT_L. T1I also sets `intack`.
- **T2** sample edge: `CPU_DAT_I[5:0]` goes into the high-address shadow and `CPU_DAT_I[7:6]` into the cycle shadow. Then:
  - If the write buffer is full, `READY_O` drops and stays low until the buffer drains. The FSM holds in GOT_H.
  - Otherwise `ADDR_O` and `CYCLE_O` load from the shadows and the FSM dispatches:
    - PCI or PCR → RD_WAIT: `MEM_RD_O`=1 and `READY_O`=0.
    - PCC → IO: `IO_STB_O` pulses for one clock and `CPU_DAT_O`=`IO_DAT_I`. `READY_O` stays 1.
    - PCW → WR_CAP, with `READY_O`=1.
- **RD_WAIT**: on the clock where `MEM_ACK_I`=1, `CPU_DAT_O` takes `MEM_DAT_I`. On the next clock `MEM_RD_O`=0, `READY_O`=1, and the FSM moves to DONE.
- **WR_CAP**: at the T3 sample edge, `WDAT_O` takes `CPU_DAT_I` and the buffer becomes full with `MEM_WR_O`=1. The FSM moves to DONE. The write address stays in `ADDR_O`.
- **Buffer drain**: `MEM_WR_O` stays high until `MEM_ACK_I`. On that clock the buffer empties; the next clock `MEM_WR_O`=0.
- **DONE**: `CPU_DAT_O` is held through the core's T3. The next T1/T1I returns the FSM to GOT_L.
- STOP and WAIT codes never change the address shadows.
- `MEM_ACK_I` is ignored outside RD_WAIT and outside a pending write.

## Timing
- A single sample edge per T-state; the FSM ignores edges with `SYNC_I`=0.
- Read latency: `MEM_RD_O` rises one clock after the T2 sample edge.
  - An ack in that first clock is a legal zero-wait transfer: `READY_O` returns high one clock after the ack.
- A write stall costs exactly the clocks until the pending ack, plus one.
- Address update is deferred by a pending write. `ADDR_O` changes only on dispatch, never while `MEM_WR_O`=1.
- An ack that coincides with a new T2 (buffer draining as a read dispatches): the buffer empties first, the dispatch happens the same clock, and `READY_O` does not drop for the buffer.
- Reset asserted mid-transfer drops all requests immediately, with no completion. `READY_O` returns to 1.

## Configuration
- `CPU_BUSCTL_INTACK_EN`
  - Defined: a PCI cycle started from T1I skips memory. `CPU_DAT_O`=`INT_VEC_I` and `READY_O` stays 1. `MEM_RD_O` stays 0.
  - Undefined: T1I is treated exactly as T1 and a normal memory fetch occurs. `INT_VEC_I` is unused.

## Structure
- Shared package `cpu_bus_pkg`:
  - T-state code constants.
  - Cycle type constants (PCI/PCC/PCR/PCW).
  - FSM state enum.
- One sub-module, `cpu_busctl_wrbuf`: the one-entry posted-write buffer (full flag, data, request/ack handshake).
- FSM, shadows and the read path live in `cpu_busctl`.

## Test plan
- Fetch: T1 with `CPU_DAT_I`=0x34, T2 with 0x12 (PCI), ack after 2 clocks with `MEM_DAT_I`=0xC7 → `ADDR_O`=0x1234, `CYCLE_O`=00, `READY_O` low for 3 clocks, `CPU_DAT_O`=0xC7.
- Write: T1=0x10, T2=0xC5, T3 data 0xAA → `ADDR_O`=0x0510, `MEM_WR_O`=1, `WDAT_O`=0xAA, `READY_O` never low.
- Write then read with ack withheld 5 clocks → `READY_O` low at the read's T2 until the ack plus one clock. `ADDR_O` holds 0x0510 until the drain completes, then switches.
- I/O: T1=0x55, T2=0x4E (PCC), `IO_DAT_I`=0x99 → `ADDR_O`=0x0E55, single-clock `IO_STB_O`, `CPU_DAT_O`=0x99.
- Interrupt: T1I with `INT_VEC_I`=0x0D → with the macro, `CPU_DAT_O`=0x0D and `MEM_RD_O` stays 0. Without the macro, a memory read occurs.
- Reset pulse during RD_WAIT → all outputs at reset values asynchronously. The next fetch works normally.
